// File: rtl/oled_frame_streamer_if.sv
// Bundle between the OLED frame streamer and its image source / SSD1306 panel.
// The master side is the streamer; the slave side is the image source plus panel.
interface oled_frame_streamer_if;
    logic [7:0] data_in;
    logic [9:0] byte_counter;
    logic       sclk;
    logic       mosi;
    logic       cs_n;
    logic       dc;
    logic       res_n;
    logic       init_done;
    logic       frame_done;

    modport master (
        input  data_in,
        output byte_counter, sclk, mosi, cs_n, dc, res_n, init_done, frame_done
    );

    modport slave (
        output data_in,
        input  byte_counter, sclk, mosi, cs_n, dc, res_n, init_done, frame_done
    );
endinterface

// File: rtl/oled_frame_streamer.sv
// SSD1306 128x64 bring-up and continuous frame streaming over 4-wire SPI (mode 0).
// state      | meaning
// RST_LOW    | res_n held low for RESET_CYCLES
// RST_WAIT   | res_n released, settle for RESET_CYCLES
// INIT       | sending the 25-byte init command list
// ADDR       | sending the 6-byte column/page window set
// FETCH      | byte_counter stable, waiting for the image source read
// SEND       | shifting one pixel byte out with dc=1
// GAP        | idle between frames
module oled_frame_streamer #(
    parameter int CLK_DIV      = 4,
    parameter int RESET_CYCLES = 1000,
    parameter int FRAME_GAP    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    oled_frame_streamer_if.master disp
);
    localparam int CNT_MAX = (RESET_CYCLES > FRAME_GAP) ? RESET_CYCLES : FRAME_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DIV_W   = $clog2(CLK_DIV + 1);

    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(FRAME_GAP - 1);
    localparam logic [CNT_W-1:0] FETCH_LOAD = CNT_W'(1);
    localparam logic [DIV_W-1:0] DIV_LOAD   = DIV_W'(CLK_DIV - 1);

    // Entries 0..24 are the init list, 25..30 the address-window sequence.
    localparam logic [7:0] CMD_ROM [31] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
        8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
        8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
        8'hAF, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
    };

    typedef enum logic [2:0] {
        S_RST_LOW, S_RST_WAIT, S_INIT, S_ADDR, S_FETCH, S_SEND, S_GAP
    } state_t;

    typedef enum logic [2:0] {
        X_IDLE, X_SETUP, X_LOW, X_HIGH, X_END
    } xfer_t;

    state_t           state;
    xfer_t            xph;
    logic [CNT_W-1:0] cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic [4:0]       idx;

    logic       start_req;
    logic [7:0] start_byte;
    logic       start_dc;
    logic       xfer_end;

    // Decides whether a new byte begins on this edge; the next byte follows the
    // cs_n-high cycle of the previous one without any extra idle time.
    always_comb begin
        start_req  = 1'b0;
        start_byte = 8'h00;
        start_dc   = 1'b0;
        xfer_end   = (xph == X_END);
        case (state)
            S_RST_WAIT: if (cnt == '0) begin
                start_req  = 1'b1;
                start_byte = CMD_ROM[0];
            end
            S_INIT, S_ADDR: if (xfer_end && idx != 5'd30) begin
                start_req  = 1'b1;
                start_byte = CMD_ROM[idx + 5'd1];
            end
            S_FETCH: if (cnt == '0) begin
                start_req  = 1'b1;
                start_byte = disp.data_in;
                start_dc   = 1'b1;
            end
            S_GAP: if (cnt == '0) begin
                start_req  = 1'b1;
                start_byte = CMD_ROM[25];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_RST_LOW;
            xph               <= X_IDLE;
            cnt               <= RST_LOAD;
            div_cnt           <= '0;
            bit_cnt           <= '0;
            shreg             <= '0;
            idx               <= '0;
            disp.byte_counter <= '0;
            disp.sclk         <= 1'b0;
            disp.mosi         <= 1'b0;
            disp.cs_n         <= 1'b1;
            disp.dc           <= 1'b0;
            disp.res_n        <= 1'b0;
            disp.init_done    <= 1'b0;
            disp.frame_done   <= 1'b0;
        end else begin
            disp.frame_done <= 1'b0;

            if (start_req) begin
                shreg     <= start_byte;
                disp.mosi <= start_byte[7];
                disp.dc   <= start_dc;
                disp.cs_n <= 1'b0;
                disp.sclk <= 1'b0;
                bit_cnt   <= 3'd7;
                xph       <= X_SETUP;
            end else begin
                case (xph)
                    X_SETUP: begin
                        xph     <= X_LOW;
                        div_cnt <= DIV_LOAD;
                    end
                    X_LOW: begin
                        if (div_cnt == '0) begin
                            disp.sclk <= 1'b1;
                            xph       <= X_HIGH;
                            div_cnt   <= DIV_LOAD;
                        end else begin
                            div_cnt <= div_cnt - 1'b1;
                        end
                    end
                    X_HIGH: begin
                        if (div_cnt == '0) begin
                            disp.sclk <= 1'b0;
                            if (bit_cnt == 3'd0) begin
                                disp.cs_n <= 1'b1;
                                xph       <= X_END;
                            end else begin
                                bit_cnt   <= bit_cnt - 1'b1;
                                shreg     <= {shreg[6:0], 1'b0};
                                disp.mosi <= shreg[6];
                                xph       <= X_LOW;
                                div_cnt   <= DIV_LOAD;
                            end
                        end else begin
                            div_cnt <= div_cnt - 1'b1;
                        end
                    end
                    X_END: begin
                        disp.mosi <= 1'b0;
                        xph       <= X_IDLE;
                    end
                    default: ;
                endcase
            end

            case (state)
                S_RST_LOW: begin
                    if (cnt == '0) begin
                        disp.res_n <= 1'b1;
                        cnt        <= RST_LOAD;
                        state      <= S_RST_WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RST_WAIT: begin
                    if (cnt == '0) begin
                        idx   <= '0;
                        state <= S_INIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_INIT: begin
                    if (xfer_end) begin
                        idx <= idx + 5'd1;
                        if (idx == 5'd24) begin
                            disp.init_done <= 1'b1;
                            state          <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    if (xfer_end) begin
                        if (idx == 5'd30) begin
                            disp.byte_counter <= '0;
                            cnt               <= FETCH_LOAD;
                            state             <= S_FETCH;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                S_FETCH: begin
                    if (cnt == '0) state <= S_SEND;
                    else           cnt   <= cnt - 1'b1;
                end
                S_SEND: begin
                    if (xfer_end) begin
                        if (disp.byte_counter == 10'd1023) begin
                            disp.byte_counter <= '0;
                            disp.frame_done   <= 1'b1;
                            cnt               <= GAP_LOAD;
                            state             <= S_GAP;
                        end else begin
                            disp.byte_counter <= disp.byte_counter + 10'd1;
                            cnt               <= FETCH_LOAD;
                            state             <= S_FETCH;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt == '0) begin
                        idx   <= 5'd25;
                        state <= S_ADDR;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_RST_LOW;
            endcase
        end
    end
endmodule
